// File: rtl/wordcell_pkg.sv
// Shared types and constants for the wordcell access controller.
// Defining WORDCELL_READBACK_EN adds the write-verify readback states.
package wordcell_pkg;

  localparam int DEFAULT_WORD_W = 8;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

`ifdef WORDCELL_READBACK_EN
  typedef enum logic [2:0] {
    IDLE, SETUP, SELECT, RELEASE, RESP, RB_SETUP, RB_SELECT, RB_RELEASE
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, SETUP, SELECT, RELEASE, RESP
  } state_t;
`endif

  // Width of a down-counter that must hold values 0 .. n-1.
  function automatic int unsigned sel_cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wordcell_addr_decoder.sv
// Combinational word address to one-hot cell select, gated by en.
// in_range is reported regardless of en so callers can range-check early.
module wordcell_addr_decoder #(
  parameter int NUM_WORDS = 4,
  parameter int ADDR_W    = 2
) (
  input  logic                 en,
  input  logic [ADDR_W-1:0]    addr,
  output logic [NUM_WORDS-1:0] sel,
  output logic                 in_range
);

  always_comb begin
    in_range = (int'(addr) < NUM_WORDS);
    sel      = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (en && in_range && (int'(addr) == i)) begin
        sel[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wordcell_array_ctrl.sv
// Sequences SETUP/SELECT/RELEASE around each wordcell access; WORDCELL_READBACK_EN verifies writes.
// Latency 2+SEL_CYCLES (doubled for verified writes); one request in flight, holds RESP until rsp_ready.
module wordcell_array_ctrl
  import wordcell_pkg::*;
#(
  parameter int WORD_W     = DEFAULT_WORD_W,
  parameter int NUM_WORDS  = 4,
  parameter int ADDR_W     = 2,
  parameter int SEL_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [WORD_W-1:0]    req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WORD_W-1:0]    rsp_rdata,
  output logic                 rsp_err,
  output logic                 cell_op,
  output logic [NUM_WORDS-1:0] cell_sel,
  output logic [WORD_W-1:0]    cell_in_bus,
  input  logic [WORD_W-1:0]    cell_out_bus
);

  localparam int              CNT_W    = sel_cnt_w(SEL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SEL_CYCLES - 1);

  state_t                 state;
  logic                   we_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [CNT_W-1:0]       cnt;
  logic [ADDR_W-1:0]      dec_addr;
  logic [NUM_WORDS-1:0]   dec_sel;
  logic                   dec_in_range;
`ifdef WORDCELL_READBACK_EN
  logic [WORD_W-1:0]      wdata_q;
`endif

  // In IDLE the incoming address is range-checked so bad requests skip the cell phases.
  assign dec_addr = (state == IDLE) ? req_addr : addr_q;

  wordcell_addr_decoder #(
    .NUM_WORDS (NUM_WORDS),
    .ADDR_W    (ADDR_W)
  ) u_addr_decoder (
    .en       (state != IDLE),
    .addr     (dec_addr),
    .sel      (dec_sel),
    .in_range (dec_in_range)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      we_q        <= OP_READ;
      addr_q      <= '0;
      cnt         <= '0;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      cell_op     <= OP_READ;
      cell_sel    <= '0;
      cell_in_bus <= '0;
`ifdef WORDCELL_READBACK_EN
      wdata_q     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            addr_q    <= req_addr;
            req_ready <= 1'b0;
            rsp_rdata <= '0;
`ifdef WORDCELL_READBACK_EN
            wdata_q   <= req_wdata;
`endif
            if (dec_in_range) begin
              state       <= SETUP;
              rsp_err     <= 1'b0;
              cell_op     <= req_we;
              cell_in_bus <= (req_we == OP_WRITE) ? req_wdata : '0;
            end else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end
          end
        end

        SETUP: begin
          state    <= SELECT;
          cell_sel <= dec_sel;
          cnt      <= CNT_LOAD;
        end

        SELECT: begin
          if (cnt == '0) begin
            state    <= RELEASE;
            cell_sel <= '0;
            if (we_q == OP_READ) begin
              rsp_rdata <= cell_out_bus;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        RELEASE: begin
          // op and in_bus were held through this cycle so the latch closed on stable data.
          cell_op     <= OP_READ;
          cell_in_bus <= '0;
`ifdef WORDCELL_READBACK_EN
          if (we_q == OP_WRITE) begin
            state <= RB_SETUP;
          end else begin
            state     <= RESP;
            rsp_valid <= 1'b1;
          end
`else
          state     <= RESP;
          rsp_valid <= 1'b1;
`endif
        end

`ifdef WORDCELL_READBACK_EN
        RB_SETUP: begin
          state    <= RB_SELECT;
          cell_sel <= dec_sel;
          cnt      <= CNT_LOAD;
        end

        RB_SELECT: begin
          if (cnt == '0) begin
            state     <= RB_RELEASE;
            cell_sel  <= '0;
            rsp_rdata <= cell_out_bus;
            rsp_err   <= (cell_out_bus != wdata_q);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        RB_RELEASE: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
        end
`endif

        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
          end
        end

        default: begin
          state       <= IDLE;
          req_ready   <= 1'b1;
          rsp_valid   <= 1'b0;
          cell_op     <= OP_READ;
          cell_sel    <= '0;
          cell_in_bus <= '0;
        end
      endcase
    end
  end

endmodule
